// File: rtl/pipe_arbiter_pkg.sv
// Shared types for the two-requester pipelined arbiter: FSM state encoding,
// source ids and a small helper mapping a source id to its serving state.
package pipe_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } arb_state_e;

   localparam logic SRC0    = 1'b0;
   localparam logic SRC1    = 1'b1;
   localparam int   BURST_W = 4;

   function automatic arb_state_e serve_of(input logic src);
      return (src == SRC1) ? SERVE1 : SERVE0;
   endfunction

endpackage

// File: rtl/pipe_arbiter_stage.sv
// One register stage of the delay pipeline carrying {valid, src, data}.
// src/data only load with a valid beat so the output holds the last beat.
module pipe_arbiter_stage
   import pipe_arbiter_pkg::*;
#(
   parameter int DW = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          clr,
   input  logic          load_valid,
   input  logic          load_src,
   input  logic [DW-1:0] load_data,
   output logic          stage_valid,
   output logic          stage_src,
   output logic [DW-1:0] stage_data
);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stage_valid <= 1'b0;
         stage_src   <= SRC0;
         stage_data  <= '0;
      end else begin
         stage_valid <= load_valid & ~clr;
         if (load_valid && !clr) begin
            stage_src  <= load_src;
            stage_data <= load_data;
         end
      end
   end

endmodule

// File: rtl/pipe_arbiter.sv
// Two-requester burst-limited arbiter feeding a fixed-latency delay pipeline.
// Optional flush input is enabled with macro PIPE_ARBITER_FLUSH_EN.
//
// state  | meaning
// IDLE   | no requester granted, waiting for a valid
// SERVE0 | requester 0 granted (req0_ready high)
// SERVE1 | requester 1 granted (req1_ready high)
module pipe_arbiter
   import pipe_arbiter_pkg::*;
#(
   parameter int DW        = 2,
   parameter int DEPTH     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
`ifdef PIPE_ARBITER_FLUSH_EN
   input  logic          flush,
`endif
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_src,
   output logic          busy
);

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   arb_state_e         state, state_nxt;
   logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
   logic               last_src, last_src_nxt;
   logic               flush_hit;
   logic               acc0, acc1;

`ifdef PIPE_ARBITER_FLUSH_EN
   assign flush_hit = flush;
`else
   assign flush_hit = 1'b0;
`endif

   assign acc0 = req0_valid & req0_ready;
   assign acc1 = req1_valid & req1_ready;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
         last_src  <= SRC1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         last_src  <= last_src_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid)
               state_nxt = serve_of(~last_src);
            else if (req0_valid)
               state_nxt = SERVE0;
            else if (req1_valid)
               state_nxt = SERVE1;
         end
         SERVE0: begin
            if (!req0_valid)
               state_nxt = req1_valid ? SERVE1 : IDLE;
            else if (burst_cnt == BURST_LAST && req1_valid)
               state_nxt = SERVE1;
         end
         SERVE1: begin
            if (!req1_valid)
               state_nxt = req0_valid ? SERVE0 : IDLE;
            else if (burst_cnt == BURST_LAST && req0_valid)
               state_nxt = SERVE0;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush_hit)
         state_nxt = IDLE;

      // A full burst with nobody waiting restarts the count in place.
      burst_cnt_nxt = burst_cnt;
      if (state_nxt != state)
         burst_cnt_nxt = '0;
      else if (acc0 || acc1)
         burst_cnt_nxt = (burst_cnt == BURST_LAST) ? '0 : burst_cnt + 1'b1;

      last_src_nxt = last_src;
      if (state_nxt != state) begin
         if (state == SERVE0)
            last_src_nxt = SRC0;
         else if (state == SERVE1)
            last_src_nxt = SRC1;
      end
   end

   always_comb begin
      req0_ready = (state == SERVE0) && !flush_hit;
      req1_ready = (state == SERVE1) && !flush_hit;
   end

   logic [DEPTH-1:0] stg_valid;
   logic [DEPTH-1:0] stg_src;
   logic [DW-1:0]    stg_data [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic          ld_valid;
      logic          ld_src;
      logic [DW-1:0] ld_data;

      if (k == 0) begin : g_head
         assign ld_valid = acc0 | acc1;
         assign ld_src   = acc1 ? SRC1 : SRC0;
         assign ld_data  = acc1 ? req1_data : req0_data;
      end else begin : g_tail
         assign ld_valid = stg_valid[k-1];
         assign ld_src   = stg_src[k-1];
         assign ld_data  = stg_data[k-1];
      end

      pipe_arbiter_stage #(.DW(DW)) u_stage (
         .sys_clk     (sys_clk),
         .sys_rst     (sys_rst),
         .clr         (flush_hit),
         .load_valid  (ld_valid),
         .load_src    (ld_src),
         .load_data   (ld_data),
         .stage_valid (stg_valid[k]),
         .stage_src   (stg_src[k]),
         .stage_data  (stg_data[k])
      );
   end

   assign out_valid = stg_valid[DEPTH-1];
   assign out_src   = stg_src[DEPTH-1];
   assign out_data  = stg_data[DEPTH-1];
   assign busy      = |stg_valid;

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter: cycle vectors with expected grants,
// plus a scoreboard of accepted beats checked against the delayed output.
module tb_pipe_arbiter;

   localparam int DW    = 2;
   localparam int DEPTH = 2;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          flush_drv;
   logic          req0_valid, req1_valid;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          out_valid, out_src, busy;
   logic [DW-1:0] out_data;

   pipe_arbiter #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
`ifdef PIPE_ARBITER_FLUSH_EN
      .flush      (flush_drv),
`endif
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .busy       (busy)
   );

   initial forever #5 sys_clk = ~sys_clk;

   typedef struct {
      bit            rst;
      bit            v0, v1;
      logic [DW-1:0] d0, d1;
      bit            r0, r1;
   } vec_t;

   typedef struct {
      logic          src;
      logic [DW-1:0] data;
      int            due;
   } beat_t;

   vec_t          tbl[$];
   beat_t         sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   logic [DW-1:0] last_d   = '0;
   logic          last_s   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void add(input bit rst, input bit v0, input bit v1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input bit r0, input bit r1);
      vec_t r;
      r.rst = rst; r.v0 = v0; r.v1 = v1; r.d0 = d0; r.d1 = d1; r.r0 = r0; r.r1 = r1;
      tbl.push_back(r);
   endfunction

   // Called at a falling edge: drive, check this cycle, advance one clock.
   task automatic step(input bit rst, input bit v0, input bit v1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input bit r0, input bit r1);
      beat_t b;
      sys_rst    = rst;
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = d0;
      req1_data  = d1;
      chk("req0_ready", 32'(req0_ready), 32'(r0));
      chk("req1_ready", 32'(req1_ready), 32'(r1));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      if (sb.size() != 0 && sb[0].due == cyc) begin
         b = sb.pop_front();
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("out_src", 32'(out_src), 32'(b.src));
         chk("out_data", 32'(out_data), 32'(b.data));
         last_d = b.data;
         last_s = b.src;
      end else begin
         chk("out_valid_idle", 32'(out_valid), 32'd0);
         chk("out_data_hold", 32'(out_data), 32'(last_d));
         chk("out_src_hold", 32'(out_src), 32'(last_s));
      end
      if (!rst && !flush_drv) begin
         if (v0 && r0) sb.push_back('{src: 1'b0, data: d0, due: cyc + DEPTH});
         if (v1 && r1) sb.push_back('{src: 1'b1, data: d1, due: cyc + DEPTH});
      end
      @(posedge sys_clk);
      cyc++;
      if (rst) begin
         sb.delete();
         last_d = '0;
         last_s = 1'b0;
      end
      if (flush_drv) sb.delete();
      @(negedge sys_clk);
   endtask

   initial begin
      sys_rst = 1'b1; flush_drv = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;

      // single requester 0 beat, then a reset
      add(0, 1, 0, 2'b01, 0, 0, 0);
      add(0, 1, 0, 2'b01, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      // both valid continuously: 4 beats src0, 4 src1, 4 src0, back-to-back
      add(0, 1, 1, 2'd3, 2'd2, 0, 0);
      for (int i = 0; i < 12; i++)
         add(0, 1, 1, DW'(i), DW'(~i), ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      // requester 1 alone for 10 beats: burst count wraps, no gaps
      add(0, 0, 1, 0, 2'd1, 0, 0);
      for (int i = 0; i < 10; i++)
         add(0, 0, 1, 0, DW'(i + 1), 0, 1);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_src", 32'(out_src), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].r0, tbl[i].r1);

      // req0 drops mid-burst while req1 waits
      step(0, 1, 0, 2'd2, 0, 0, 0);
      step(0, 1, 0, 2'd3, 0, 1, 0);
      step(0, 1, 1, 2'd1, 2'd2, 1, 0);
      step(0, 0, 1, 0, 2'd2, 1, 0);
      chk("last_src_after_drop", 32'(dut.last_src), 32'd0);
      step(0, 0, 1, 0, 2'd3, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // reset with two beats in the pipeline; the second must never emerge
      step(0, 1, 0, 2'd1, 0, 0, 0);
      step(0, 1, 0, 2'd2, 0, 1, 0);
      step(0, 1, 0, 2'd3, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 0, 0, 0, 0);

`ifdef PIPE_ARBITER_FLUSH_EN
      // flush during streaming: no ready that cycle, pipeline emptied, resume
      step(0, 1, 1, 2'd1, 2'd2, 0, 0);
      step(0, 1, 1, 2'd2, 2'd2, 1, 0);
      step(0, 1, 1, 2'd3, 2'd2, 1, 0);
      flush_drv = 1'b1;
      step(0, 1, 1, 2'd0, 2'd2, 0, 0);
      flush_drv = 1'b0;
      step(0, 1, 0, 2'd1, 0, 0, 0);
      step(0, 1, 0, 2'd1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
`endif

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
